// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // Counter width for a bound, never narrower than one bit.
    function automatic int width_of(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Reloadable down-counter used for the BLANK and SHOW dwell times.
module seg_scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reload,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (reload)
            count <= load_value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous display updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              data_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick,
    output logic                    load_pending
);
    import seg_scan_pkg::*;

    localparam int IDX_W     = width_of(NUM_DIGITS);
    localparam int DWELL_MAX = (BLANK_CYCLES > REFRESH_DIV) ? BLANK_CYCLES : REFRESH_DIV;
    localparam int CNT_W     = width_of(DWELL_MAX);
    localparam int DW        = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      SHOW_LD    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_LD   = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [DW-1:0]           active, active_n, shadow, shadow_n;
    logic                    pending_n;
    logic                    reload, done, frame_end, commit;
    logic [CNT_W-1:0]        reload_val;
    logic [NUM_DIGITS-1:0]   an_n_n;
    bcd_t                    data_n;

    seg_scan_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .reload     (reload),
        .load_value (reload_val),
        .done       (done)
    );

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        reload     = 1'b0;
        reload_val = SHOW_LD;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                idx_n = '0;
                if (enable) begin
                    reload = 1'b1;
                    if (BLANK_CYCLES > 0) begin
                        state_n    = BLANK;
                        reload_val = BLANK_LD;
                    end else begin
                        state_n = SHOW;
                    end
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (done) begin
                    state_n = SHOW;
                    reload  = 1'b1;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (done) begin
                    reload    = 1'b1;
                    frame_end = (idx == LAST_IDX);
                    idx_n     = frame_end ? '0 : idx + 1'b1;
                    if (BLANK_CYCLES > 0) begin
                        state_n    = BLANK;
                        reload_val = BLANK_LD;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // Loads while scanning are parked in shadow until a frame boundary or scan stop,
    // so a frame never mixes old and new digits; a coincident load wins over shadow.
    always_comb begin
        commit    = frame_end || (state != IDLE && state_n == IDLE);
        active_n  = active;
        shadow_n  = shadow;
        pending_n = load_pending;
        if (load && (state == IDLE || commit)) begin
            active_n  = digits_in;
            pending_n = 1'b0;
        end else if (load) begin
            shadow_n  = digits_in;
            pending_n = 1'b1;
        end else if (commit && load_pending) begin
            active_n  = shadow;
            pending_n = 1'b0;
        end
    end

    always_comb begin
        data_n = (state_n == IDLE) ? 4'h0 : active_n[4*idx_n +: 4];
        an_n_n = AN_ALL_OFF;
`ifdef SEG_SCAN_LZB_EN
        if (state_n == SHOW && (idx_n == '0 || (active_n >> (4*idx_n)) != '0))
            an_n_n[idx_n] = 1'b0;
`else
        if (state_n == SHOW)
            an_n_n[idx_n] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            active       <= '0;
            shadow       <= '0;
            load_pending <= 1'b0;
            data_out     <= 4'h0;
            an_n         <= AN_ALL_OFF;
            frame_tick   <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            active       <= active_n;
            shadow       <= shadow_n;
            load_pending <= pending_n;
            data_out     <= data_n;
            an_n         <= an_n_n;
            frame_tick   <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: vector table, corner sequences, random run vs. timeline model.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 2;
    localparam int DP = BC + RD;
    localparam int FP = ND * DP;
`ifdef SEG_SCAN_LZB_EN
    localparam int EXP_LIT = 8;
`else
    localparam int EXP_LIT = 16;
`endif

    logic        clk, reset, enable, load;
    logic [15:0] digits_in;
    logic [3:0]  data_out;
    logic [3:0]  an_n;
    logic        frame_tick, load_pending;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .digits_in    (digits_in),
        .data_out     (data_out),
        .an_n         (an_n),
        .frame_tick   (frame_tick),
        .load_pending (load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model: scan position is just the cycle count since enable.
    logic        m_scan;
    int          m_t;
    logic [15:0] m_active, m_shadow;
    logic        m_pend, m_tick;

    task automatic model_reset();
        m_scan = 0; m_t = 0; m_active = 0; m_shadow = 0; m_pend = 0; m_tick = 0;
    endtask

    task automatic model_commit(input logic ld, input logic [15:0] din);
        if (ld) begin
            m_active = din; m_pend = 0;
        end else if (m_pend) begin
            m_active = m_shadow; m_pend = 0;
        end
    endtask

    task automatic model_edge(input logic en, input logic ld, input logic [15:0] din);
        logic boundary;
        m_tick = 0;
        if (!m_scan) begin
            if (ld) begin m_active = din; m_pend = 0; end
            if (en) begin m_scan = 1; m_t = 0; end
        end else begin
            boundary = ((m_t % FP) == FP - 1);
            if (!en) begin
                m_scan = 0;
                model_commit(ld, din);
            end else begin
                m_t++;
                if (boundary) begin
                    m_tick = 1;
                    model_commit(ld, din);
                end else if (ld) begin
                    m_shadow = din; m_pend = 1;
                end
            end
        end
    endtask

    function automatic logic lit(input int d);
`ifdef SEG_SCAN_LZB_EN
        return (d == 0) || ((m_active >> (4*d)) != 16'h0);
`else
        return (d < ND);
`endif
    endfunction

    function automatic logic [9:0] model_out();
        logic [3:0] an, data;
        int ph, d;
        an = 4'hF; data = 4'h0;
        if (m_scan) begin
            ph = m_t % DP;
            d  = (m_t / DP) % ND;
            data = m_active[4*d +: 4];
            if (ph >= BC && lit(d)) an = ~(4'b0001 << d);
        end
        return {an, data, m_tick, m_pend};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic ld, input logic [15:0] din);
        enable = en; load = ld; digits_in = din;
        @(posedge clk);
        model_edge(en, ld, din);
        #1;
        check("model", {an_n, data_out, frame_tick, load_pending}, {22'h0, model_out()});
    endtask

    task automatic run_to_phase(input int pos);
        int k;
        for (k = 0; k < 2*FP && !(m_scan && (m_t % FP) == pos); k++) step(1, 0, 16'h0);
        if (k == 2*FP) check("run_to_phase_timeout", k, 0);
    endtask

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] din;
        int          n;
        logic [3:0]  an;
        logic [3:0]  data;
        logic        tick;
        logic        pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic ld, logic [15:0] din, int n,
                                logic [3:0] an, logic [3:0] data, logic tick, logic pend);
        vec_t v;
        v.en = en; v.ld = ld; v.din = din; v.n = n;
        v.an = an; v.data = data; v.tick = tick; v.pend = pend;
        return v;
    endfunction

    initial begin
        int lit_cnt, tick_at, k;

        vecs.push_back(mk(0, 1, 16'h1234, 1, 4'hF, 4'h0, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0, 2, 4'hF, 4'h4, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0, 4, 4'hE, 4'h4, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0, 2, 4'hF, 4'h3, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0, 4, 4'hD, 4'h3, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0, 2, 4'hF, 4'h2, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0, 4, 4'hB, 4'h2, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0, 2, 4'hF, 4'h1, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0, 4, 4'h7, 4'h1, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0, 1, 4'hF, 4'h4, 1, 0));
        vecs.push_back(mk(1, 0, 16'h0, 1, 4'hF, 4'h4, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0, 4, 4'hE, 4'h4, 0, 0));

        reset = 1; enable = 0; load = 0; digits_in = 0;
        model_reset();
        #2;
        check("reset_an_n", an_n, 4'hF);
        check("reset_data", data_out, 4'h0);
        check("reset_tick", frame_tick, 1'b0);
        check("reset_pend", load_pending, 1'b0);
        @(posedge clk); #1;
        reset = 0;

        // Basic frame of 1234, table driven
        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                step(vecs[i].en, vecs[i].ld, vecs[i].din);
                check($sformatf("vec%0d", i), {an_n, data_out, frame_tick, load_pending},
                      {vecs[i].an, vecs[i].data, vecs[i].tick, vecs[i].pend});
            end
        end

        // Mid-frame load is deferred to the boundary
        run_to_phase(5);
        step(1, 1, 16'h5678);
        check("defer_pend", load_pending, 1'b1);
        check("defer_data_old", data_out, 4'h3);
        for (k = 0; k < 2*FP && frame_tick !== 1'b1; k++) begin
            check("defer_pend_hold", load_pending, 1'b1);
            step(1, 0, 16'h0);
        end
        check("defer_tick_seen", frame_tick, 1'b1);
        check("defer_data_new", data_out, 4'h8);
        check("defer_pend_clr", load_pending, 1'b0);

        // Two loads in a frame, then a load on the boundary edge wins
        run_to_phase(8);
        step(1, 1, 16'h1111);
        step(1, 0, 16'h0);
        step(1, 1, 16'h2222);
        check("multi_pend", load_pending, 1'b1);
        run_to_phase(FP - 1);
        step(1, 1, 16'h3333);
        check("bnd_tick", frame_tick, 1'b1);
        check("bnd_data", data_out, 4'h3);
        check("bnd_pend", load_pending, 1'b0);
        step(1, 0, 16'h0);
        check("bnd_pend_after", load_pending, 1'b0);

        // Enable drop while digit 2 is lit, then restart
        run_to_phase(2*DP + BC + 1);
        check("drop_lit", an_n, 4'hB);
        step(0, 0, 16'h0);
        check("drop_an", an_n, 4'hF);
        check("drop_data", data_out, 4'h0);
        step(0, 0, 16'h0);
        step(1, 0, 16'h0);
        check("restart_blank", an_n, 4'hF);
        step(1, 0, 16'h0);
        step(1, 0, 16'h0);
        check("restart_d0", an_n, 4'hE);

        // Asynchronous reset during SHOW
        run_to_phase(DP + BC + 1);
        check("pre_reset_lit", an_n, 4'hD);
        #3 reset = 1;
        #1;
        check("async_an", an_n, 4'hF);
        check("async_data", data_out, 4'h0);
        check("async_pend", load_pending, 1'b0);
        model_reset();
        @(posedge clk); #1;
        reset = 0;

        // Leading-zero pattern: lit cycles per frame and frame period
        step(0, 1, 16'h0070);
        for (k = 0; k < 2*FP && frame_tick !== 1'b1; k++) step(1, 0, 16'h0);
        check("lzb_first_tick", frame_tick, 1'b1);
        lit_cnt = 0; tick_at = 0;
        for (int c = 1; c <= FP; c++) begin
            if (an_n != 4'hF) lit_cnt++;
            step(1, 0, 16'h0);
            if (frame_tick && tick_at == 0) tick_at = c;
        end
        check("lzb_lit_cycles", lit_cnt, EXP_LIT);
        check("lzb_period", tick_at, FP);

        // Random traffic against the model
        for (int r = 0; r < 400; r++)
            step($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0, 16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. One shared ssegment BCD decoder serves all digits.
- Holds NUM_DIGITS BCD nibbles and presents one nibble at a time on data_out, which drives the decoder input.
- Enables the matching digit anode for a fixed dwell time.
- Inserts a blanking gap between digits to prevent ghosting.
- Sits between the value-producing logic (counters, measurement blocks) and the decoder/pin drivers.

Parameters:
NUM_DIGITS, 4, digits scanned; legal range 1..8.
REFRESH_DIV, 1000, clk cycles each digit is lit (SHOW dwell); must be >= 1.
BLANK_CYCLES, 8, clk cycles with all anodes off before each digit; 0 skips BLANK entirely.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  scan enable; low holds the display dark.
load  input  1  single-cycle strobe; captures digits_in into the shadow register.
digits_in  input  4*NUM_DIGITS  BCD nibbles; [3:0] is digit 0 (rightmost, least significant).
data_out  output  4  BCD nibble for the shared ssegment decoder.
an_n  output  NUM_DIGITS  active-low anode enables; at most one bit low at any time.
frame_tick  output  1  one-cycle pulse at the end of each complete scan frame.
load_pending  output  1  shadow holds a value not yet committed to the display.

Behaviour:
- One clock domain (clk). reset is asynchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, idx=0, dwell counter=0, active=0, shadow=0, data_out=4'h0, an_n=all 1s, frame_tick=0, load_pending=0.
- IDLE (enable=0):
  - an_n all 1s, data_out=0, idx=0.
  - A load commits digits_in directly to active on the next edge; load_pending stays 0.
  - enable=1 moves to BLANK, or to SHOW if BLANK_CYCLES=0.
- BLANK:
  - an_n all 1s, data_out=active[idx].
  - Lasts exactly BLANK_CYCLES cycles, then SHOW.
- SHOW:
  - an_n[idx]=0, all other bits 1; data_out=active[idx].
  - Lasts exactly REFRESH_DIV cycles, then BLANK, or SHOW of the next digit if BLANK_CYCLES=0.
  - idx increments on the SHOW exit edge.
- Frame boundary (SHOW exit with idx=NUM_DIGITS-1):
  - idx wraps to 0 and frame_tick=1 for that one cycle.
  - If load_pending=1, shadow copies to active and load_pending clears.
- Digit period = BLANK_CYCLES+REFRESH_DIV. Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV).
- Load while scanning: shadow<=digits_in and load_pending<=1. The display changes only at the next frame boundary, so a frame never tears.
- Repeated loads before a boundary: last one wins.
- Load coinciding with a frame boundary: digits_in goes straight to active and load_pending ends at 0; newest value wins.
- enable falling mid-scan: the next edge enters IDLE with anodes off and idx=0. A pending shadow commits on that same edge.
- reset mid-scan: anodes go off immediately (asynchronous); all state returns to reset values.
- Nibbles 10..15 pass through unchanged; decoding them is the decoder's concern.
- Counter widths: $clog2 of each bound, minimum 1 bit. The dwell counter counts down from its load value to 0.

Optional Feature:
SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined: during SHOW, an_n stays all 1s for any digit i>0 whose nibble and all higher nibbles in active are 0. Digit 0 is always lit. Timing, idx sequencing and frame_tick are unchanged.
- Undefined: every digit is lit regardless of value.

Decomposition:
- Package seg_scan_pkg: state enum (IDLE, BLANK, SHOW), localparam AN_OFF (all 1s), BCD nibble typedef.
- Sub-module seg_scan_timer: a reloadable down-counter with a load value input and a done output. Provides the BLANK and SHOW dwell. The FSM, shadow/active registers and the anode decode stay in seg_scan_ctrl.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.
1. Reset, enable=1, load digits_in=16'h1234 while in IDLE -> data_out sequence 4,3,2,1; an_n=1110/1101/1011/0111 each for 4 cycles, separated by 2 cycles of 1111; frame_tick every 24 cycles.
2. Load 16'h5678 at cycle 5 of a frame -> digits 1234 continue to the boundary; load_pending=1 until the boundary; next frame shows 8,7,6,5.
3. Loads 16'h1111 then 16'h2222 in one frame, then a load of 16'h3333 exactly on the frame_tick edge -> next frame shows 3333; load_pending=0 afterwards.
4. Drop enable while digit 2 is lit -> next cycle an_n=1111, idx=0. Re-enable -> scan restarts at digit 0 after BLANK.
5. Assert reset during SHOW -> an_n=1111 within the same cycle (asynchronous); all outputs at reset values.
6. With SEG_SCAN_LZB_EN defined, load 16'h0070 -> digits 0 and 1 lit; digits 2 and 3 stay dark in their SHOW slots; frame period stays 24 cycles.
